cam_pixfront: RTL and testbench
===============================

// Module: cam_pixfront
// PURPOSE
//  Parametrised sensor pixel front-end for the camera datapath: registers NCH parallel DW-bit
//  sensor channels and selects an OW-bit window per channel by a gain code. Generates the internal
//  periodic test sync (long pulse once per group of periods) and muxes it with an external sync.
//  Counts sync edges after reset to flag "sensor ready". Sits between the sensor pins and the data/LVDS path.
// PARAMETERS
//  NCH      10      number of parallel pixel channels
//  DW       10      sensor sample width (bits)
//  OW       8       output pixel width (bits); DW>=OW
//  GW       2       gain code width; 2**GW-1 >= DW-OW
//  PERIOD   546875  internal sync period in clk cycles (>=4)
//  NPER     120     periods per group; last period of each group emits the long pulse
//  PW_SHORT 329     normal sync pulse width, cycles (1..PERIOD-2)
//  PW_LONG  657     long sync pulse width, cycles (1..PERIOD-2)
//  INIT_FR  10      sync rising edges after reset before rdy asserts (1..255)
// PORTS
//  clk      in   1         system clock, all logic on rising edge
//  init     in   1         synchronous active-high reset
//  id       in   NCH*DW    sensor samples, channel k at [k*DW +: DW]
//  ival     in   1         id valid this cycle
//  gain     in   GW        window select; 0 = MSBs, larger = lower window
//  od       out  NCH*OW    windowed pixels, channel k at [k*OW +: OW]
//  oval     out  1         od valid
//  tp_en    in   1         1 = internal test sync, 0 = external sync
//  ext_syn  in   1         external sync, asynchronous to clk
//  syn      out  1         selected sync, registered
//  syn_rise out  1         one-cycle pulse on syn rising edge
//  rdy      out  1         high once INIT_FR syn rising edges have been seen since reset
// BEHAVIOUR
//  - Reset (init=1 at an edge): od=0, oval=0, syn=0, syn_rise=0, rdy=0; all counters, sync FFs, pipeline cleared.
//    Mid-operation reset flushes in-flight samples: no oval for data that entered before init.
//  - Pixel pipe, latency 2: cycle 1 registers id, ival, gain together; cycle 2 computes od and oval.
//    A gain change applies exactly from the sample registered with it; no mixing within a sample.
//  - Window: sel = min(gain, DW-OW); sh = DW-OW-sel; od_k = (id_k >> sh)[OW-1:0].
//    Example DW=10, OW=8: gain 0 -> [9:2], 1 -> [8:1], 2/3 -> [7:0].
//  - oval follows ival with 2-cycle delay. od is updated only when the stage-1 valid is 1,
//    otherwise it holds its value.
//  - Sync generator: cnt counts 0..PERIOD-1 and wraps. grp counts 0..NPER-1 and increments on each cnt wrap.
//    On the cycle after a wrap, int_syn rises and stays high for W cycles.
//    W = PW_LONG if that wrap moved grp from NPER-1 to 0, else W = PW_SHORT.
//    Pulse-width counter is cleared at each pulse start.
//  - ext_syn goes through a 2-FF synchroniser. syn <= tp_en ? int_syn : ext_sync2.
//    The generator free-runs regardless of tp_en; switching tp_en mid-pulse is allowed and
//    may yield a truncated pulse.
//  - syn_rise = syn & ~syn_d (one cycle, coincident with the first high cycle of syn).
//  - fcnt (8-bit) increments on syn_rise and saturates at INIT_FR; rdy = (fcnt==INIT_FR), registered.
//    rdy stays high until init.
// CONFIGURATION
//  CAM_PIX_SAT_EN defined: if any id_k bit above the selected window is 1, od_k = all ones (saturate).
//  CAM_PIX_SAT_EN undefined: upper bits are discarded (plain truncation, wrap-around artefacts).
//  Latency is identical in both builds.
// STRUCTURE
//  Package cam_pkg: clog2 function; pixel/window width constants;
//    sync pulse-type enum (SYN_SHORT, SYN_LONG).
//  Sub-module cam_syngen: cnt/grp/pulse counters, produces int_syn.
//    Parameters PERIOD, NPER, PW_SHORT, PW_LONG.
//  Top level holds the pixel pipe, synchroniser, mux, edge detect and the rdy counter.
// TESTING
//  1 Pixel window, DW=10 OW=8: id_0=10'h2F5, ival=1, gain=0/1/2/3 -> od_0=8'hBD/8'h7A/8'hF5/8'hF5,
//    each 2 cycles later.
//  2 Saturation, id_0=10'h3F0, gain=2: SAT_EN -> od_0=8'hFF; without SAT_EN -> 8'hF0.
//  3 Sync gen, PERIOD=20 NPER=3 PW_SHORT=3 PW_LONG=6, tp_en=1: pulses of 3,3,6 cycles repeating,
//    rises 20 cycles apart.
//  4 rdy, INIT_FR=4: 4 ext_syn pulses (tp_en=0) -> rdy rises 1 cycle after the 4th syn_rise.
//    Further pulses keep rdy=1.
//  5 Reset mid-stream: init=1 for 1 cycle while ival=1 -> oval=0, od=0 next cycle, rdy=0;
//    valid output resumes 2 cycles after first ival.
//  6 ext_syn glitch-free 1-cycle pulse -> syn high 1 cycle, 3 cycles later; syn_rise coincides.

Source files
------------

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cam_pkg
//  Purpose  : Shared constants, sync pulse-type enum and clog2 helper for the
//             camera pixel front-end.
//  Revision : 1.0 - initial release
// ============================================================================
package cam_pkg;

   // Default pixel / window geometry
   localparam int c_NCH = 10;          // parallel pixel channels
   localparam int c_DW  = 10;          // sensor sample width
   localparam int c_OW  = 8;           // output pixel width
   localparam int c_GW  = 2;           // gain code width

   // Kind of pulse currently being emitted by the sync generator
   typedef enum logic {
      SYN_SHORT = 1'b0,
      SYN_LONG  = 1'b1
   } syn_type_e;

   // Bits needed to hold values 0..v-1; never less than one bit
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >> 1) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cam_syngen.sv
`default_nettype none
// ============================================================================
//  Module   : cam_syngen
//  Purpose  : Internal periodic test sync. A pulse starts on the cycle after
//             every period wrap; the wrap that closes a group of NPER periods
//             produces a long pulse, all others a short one.
//  Revision : 1.0 - initial release
// ============================================================================
module cam_syngen
   import cam_pkg::*;
#(
   parameter int PERIOD   = 546875,
   parameter int NPER     = 120,
   parameter int PW_SHORT = 329,
   parameter int PW_LONG  = 657
)(
   input  logic clk,
   input  logic rst,
   output logic o_int_syn
);

   localparam int c_CW    = clog2(PERIOD);
   localparam int c_GRW   = clog2(NPER);
   localparam int c_PWMAX = (PW_LONG > PW_SHORT) ? PW_LONG : PW_SHORT;
   localparam int c_PWW   = clog2(c_PWMAX);

   logic [c_CW-1:0]  r_cnt;
   logic [c_GRW-1:0] r_grp;
   logic [c_PWW-1:0] r_pcnt;
   logic             r_syn;
   syn_type_e        r_ptype;

   logic w_wrap;
   logic w_grp_wrap;
   logic w_plast;

   assign w_wrap     = (r_cnt == c_CW'(PERIOD - 1));
   assign w_grp_wrap = (r_grp == c_GRW'(NPER - 1));
   // Last high cycle of the current pulse, width chosen when it started
   assign w_plast    = (r_ptype == SYN_LONG) ? (r_pcnt == c_PWW'(PW_LONG - 1))
                                             : (r_pcnt == c_PWW'(PW_SHORT - 1));

   // Period/group counters and pulse-width timer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_grp   <= '0;
         r_pcnt  <= '0;
         r_syn   <= 1'b0;
         r_ptype <= SYN_SHORT;
      end else begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
         if (w_wrap) begin
            r_grp   <= w_grp_wrap ? '0 : r_grp + 1'b1;
            r_syn   <= 1'b1;
            r_pcnt  <= '0;
            r_ptype <= w_grp_wrap ? SYN_LONG : SYN_SHORT;
         end else if (r_syn) begin
            if (w_plast) begin
               r_syn <= 1'b0;
            end else begin
               r_pcnt <= r_pcnt + 1'b1;
            end
         end
      end
   end

   assign o_int_syn = r_syn;

endmodule
`default_nettype wire

// File: rtl/cam_pixfront.sv
`default_nettype none
// ============================================================================
//  Module   : cam_pixfront
//  Purpose  : Sensor pixel front-end. Two-stage pixel pipe selecting an
//             OW-bit window per channel by gain code, internal/external sync
//             mux with synchroniser and edge detect, and a sensor-ready flag.
//  Config   : CAM_PIX_SAT_EN - saturate a pixel to all ones when bits above
//             the selected window are set (default: plain truncation).
//  Revision : 1.0 - initial release
// ============================================================================
module cam_pixfront
   import cam_pkg::*;
#(
   parameter int NCH      = c_NCH,
   parameter int DW       = c_DW,
   parameter int OW       = c_OW,
   parameter int GW       = c_GW,
   parameter int PERIOD   = 546875,
   parameter int NPER     = 120,
   parameter int PW_SHORT = 329,
   parameter int PW_LONG  = 657,
   parameter int INIT_FR  = 10
)(
   input  logic              clk,
   input  logic              init,
   input  logic [NCH*DW-1:0] id,
   input  logic              ival,
   input  logic [GW-1:0]     gain,
   output logic [NCH*OW-1:0] od,
   output logic              oval,
   input  logic              tp_en,
   input  logic              ext_syn,
   output logic              syn,
   output logic              syn_rise,
   output logic              rdy
);

   localparam logic [GW-1:0] c_DIFF = GW'(DW - OW);

   // ---------------- pixel pipe ----------------
   logic [NCH*DW-1:0] r_id;
   logic              r_ival;
   logic [GW-1:0]     r_gain;
   logic [NCH*OW-1:0] r_od;
   logic              r_oval;

   logic [GW-1:0]     w_sel;
   logic [GW-1:0]     w_sh;
   logic [NCH*OW-1:0] w_pix;

   // Gains beyond the available headroom all map to the LSB window
   assign w_sel = (r_gain > c_DIFF) ? c_DIFF : r_gain;
   assign w_sh  = c_DIFF - w_sel;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
`ifdef CAM_PIX_SAT_EN
      logic w_over;
      assign w_over = |((r_id[k*DW +: DW] >> w_sh) >> OW);
      assign w_pix[k*OW +: OW] = w_over ? {OW{1'b1}} : OW'(r_id[k*DW +: DW] >> w_sh);
`else
      assign w_pix[k*OW +: OW] = OW'(r_id[k*DW +: DW] >> w_sh);
`endif
   end

   // Stage 1 captures sample, valid and gain together; stage 2 windows
   always_ff @(posedge clk) begin
      if (init) begin
         r_id   <= '0;
         r_ival <= 1'b0;
         r_gain <= '0;
         r_od   <= '0;
         r_oval <= 1'b0;
      end else begin
         r_id   <= id;
         r_ival <= ival;
         r_gain <= gain;
         r_oval <= r_ival;
         if (r_ival) begin
            r_od <= w_pix;
         end
      end
   end

   // ---------------- sync path ----------------
   logic       w_int_syn;
   logic       r_es1;
   logic       r_es2;
   logic       r_syn;
   logic       r_syn_d;
   logic [7:0] r_fcnt;
   logic       r_rdy;
   logic       w_syn_rise;
   logic [7:0] w_fcnt_nxt;

   cam_syngen #(
      .PERIOD   (PERIOD),
      .NPER     (NPER),
      .PW_SHORT (PW_SHORT),
      .PW_LONG  (PW_LONG)
   ) u_syngen (
      .clk       (clk),
      .rst       (init),
      .o_int_syn (w_int_syn)
   );

   assign w_syn_rise = r_syn & ~r_syn_d;
   // Frame counter saturates at the ready threshold
   assign w_fcnt_nxt = (w_syn_rise && (r_fcnt != 8'(INIT_FR))) ? r_fcnt + 8'd1 : r_fcnt;

   // Synchroniser, source mux, edge-detect history and ready counter
   always_ff @(posedge clk) begin
      if (init) begin
         r_es1   <= 1'b0;
         r_es2   <= 1'b0;
         r_syn   <= 1'b0;
         r_syn_d <= 1'b0;
         r_fcnt  <= '0;
         r_rdy   <= 1'b0;
      end else begin
         r_es1   <= ext_syn;
         r_es2   <= r_es1;
         r_syn   <= tp_en ? w_int_syn : r_es2;
         r_syn_d <= r_syn;
         r_fcnt  <= w_fcnt_nxt;
         r_rdy   <= (w_fcnt_nxt == 8'(INIT_FR));
      end
   end

   assign od       = r_od;
   assign oval     = r_oval;
   assign syn      = r_syn;
   assign syn_rise = w_syn_rise;
   assign rdy      = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_cam_pixfront.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cam_pixfront
//  Purpose  : Directed self-checking bench for cam_pixfront (pixel windows,
//             saturation option CAM_PIX_SAT_EN, sync generator, ext sync,
//             ready flag, mid-stream reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cam_pixfront;

   localparam int NCH = 2;
   localparam int DW  = 10;
   localparam int OW  = 8;
   localparam int GW  = 2;

   logic              clk;
   logic              init;
   logic [NCH*DW-1:0] id;
   logic              ival;
   logic [GW-1:0]     gain;
   logic [NCH*OW-1:0] od;
   logic              oval;
   logic              tp_en;
   logic              ext_syn;
   logic              syn;
   logic              syn_rise;
   logic              rdy;

   int n_checks = 0;
   int n_fail   = 0;

   cam_pixfront #(
      .NCH(NCH), .DW(DW), .OW(OW), .GW(GW),
      .PERIOD(20), .NPER(3), .PW_SHORT(3), .PW_LONG(6), .INIT_FR(4)
   ) dut (
      .clk(clk), .init(init), .id(id), .ival(ival), .gain(gain),
      .od(od), .oval(oval), .tp_en(tp_en), .ext_syn(ext_syn),
      .syn(syn), .syn_rise(syn_rise), .rdy(rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive a 2-cycle ext_syn pulse and wait (bounded) for the syn rise
   task automatic ext_pulse(output logic found);
      ext_syn = 1'b1;
      tick;
      tick;
      ext_syn = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 8 && !found; n++) begin
         tick;
         if (syn_rise) found = 1'b1;
      end
   endtask

   // Pixel vectors: channel 0/1 sample, gain, valid, expected od/oval
   logic [9:0] v_id0 [7];
   logic [9:0] v_id1 [7];
   logic [1:0] v_g   [7];
   logic       v_v   [7];
   logic [7:0] e0    [7];
   logic [7:0] e1    [7];

   initial begin
      v_id0[0] = 10'h2F5; v_id1[0] = 10'h3FF; v_g[0] = 2'd0; v_v[0] = 1'b1;
      v_id0[1] = 10'h2F5; v_id1[1] = 10'h001; v_g[1] = 2'd1; v_v[1] = 1'b1;
      v_id0[2] = 10'h2F5; v_id1[2] = 10'h0AB; v_g[2] = 2'd2; v_v[2] = 1'b1;
      v_id0[3] = 10'h2F5; v_id1[3] = 10'h1C3; v_g[3] = 2'd3; v_v[3] = 1'b1;
      v_id0[4] = 10'h3F0; v_id1[4] = 10'h155; v_g[4] = 2'd2; v_v[4] = 1'b1;
      v_id0[5] = 10'h000; v_id1[5] = 10'h000; v_g[5] = 2'd0; v_v[5] = 1'b0;
      v_id0[6] = 10'h000; v_id1[6] = 10'h000; v_g[6] = 2'd0; v_v[6] = 1'b1;
`ifdef CAM_PIX_SAT_EN
      e0[0] = 8'hBD; e1[0] = 8'hFF;
      e0[1] = 8'hFF; e1[1] = 8'h00;
      e0[2] = 8'hFF; e1[2] = 8'hAB;
      e0[3] = 8'hFF; e1[3] = 8'hFF;
      e0[4] = 8'hFF; e1[4] = 8'hFF;
      e0[5] = 8'hFF; e1[5] = 8'hFF;
`else
      e0[0] = 8'hBD; e1[0] = 8'hFF;
      e0[1] = 8'h7A; e1[1] = 8'h00;
      e0[2] = 8'hF5; e1[2] = 8'hAB;
      e0[3] = 8'hF5; e1[3] = 8'hC3;
      e0[4] = 8'hF0; e1[4] = 8'h55;
      e0[5] = 8'hF0; e1[5] = 8'h55;
`endif
      e0[6] = 8'h00; e1[6] = 8'h00;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic found;
      int   rise_t [6];
      int   width  [6];
      int   np;
      int   cur;

      init = 1'b1; id = '0; ival = 1'b0; gain = '0; tp_en = 1'b0; ext_syn = 1'b0;
      tick;
      tick;
      init = 1'b0;
      check("rst_od", od, 0);
      check("rst_oval", oval, 0);
      check("rst_syn", syn, 0);
      check("rst_syn_rise", syn_rise, 0);
      check("rst_rdy", rdy, 0);

      // Pixel pipe, back-to-back vectors, result 2 cycles after drive
      for (int k = 0; k <= 7; k++) begin
         if (k < 7) begin
            id   = {v_id1[k], v_id0[k]};
            gain = v_g[k];
            ival = v_v[k];
         end else begin
            ival = 1'b0;
         end
         tick;
         if (k >= 1) begin
            check($sformatf("od0_v%0d", k - 1), od[7:0], e0[k-1]);
            check($sformatf("od1_v%0d", k - 1), od[15:8], e1[k-1]);
            check($sformatf("oval_v%0d", k - 1), oval, v_v[k-1]);
         end
      end

      // Single-cycle external sync: syn appears 3 cycles later for 1 cycle
      ext_syn = 1'b1;
      tick;
      ext_syn = 1'b0;
      check("ext_syn_e1", syn, 0);
      tick;
      check("ext_syn_e2", syn, 0);
      tick;
      check("ext_syn_e3", syn, 1);
      check("ext_rise_e3", syn_rise, 1);
      tick;
      check("ext_syn_e4", syn, 0);
      check("ext_rise_e4", syn_rise, 0);
      check("rdy_after1", rdy, 0);

      // Ready after the 4th rise, sticky afterwards
      for (int p = 2; p <= 3; p++) begin
         ext_pulse(found);
         check($sformatf("ext_found_%0d", p), found, 1);
         repeat (4) tick;
      end
      check("rdy_after3", rdy, 0);
      ext_pulse(found);
      check("ext_found_4", found, 1);
      check("rdy_at_rise4", rdy, 0);
      tick;
      check("rdy_after4", rdy, 1);
      repeat (4) tick;
      ext_pulse(found);
      check("ext_found_5", found, 1);
      tick;
      check("rdy_after5", rdy, 1);

      // Internal sync generator: widths 3,3,6 repeating, 20 cycles apart
      init  = 1'b1;
      tp_en = 1'b1;
      tick;
      init = 1'b0;
      check("rdy_reset2", rdy, 0);
      np  = 0;
      cur = -1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         tick;
         if (syn_rise && np < 6) begin
            rise_t[np] = cyc;
            width[np]  = 0;
            cur        = np;
            np++;
         end
         if (cur >= 0) begin
            if (syn) width[cur]++;
            else     cur = -1;
         end
         if (np == 6 && cur == -1) break;
      end
      check("tp_pulses", np, 6);
      for (int i = 0; i < np; i++) begin
         check($sformatf("tp_width_%0d", i), width[i], ((i % 3) == 2) ? 6 : 3);
         if (i > 0) check($sformatf("tp_gap_%0d", i), rise_t[i] - rise_t[i-1], 20);
      end
      check("tp_rdy", rdy, 1);

      // Mid-stream reset flushes the in-flight sample
      tp_en = 1'b0;
      id    = {10'h000, 10'h3FF};
      gain  = 2'd0;
      ival  = 1'b1;
      tick;
      init = 1'b1;
      tick;
      check("mid_oval", oval, 0);
      check("mid_od", od, 0);
      check("mid_rdy", rdy, 0);
      check("mid_syn", syn, 0);
      init = 1'b0;
      id   = {10'h000, 10'h2F5};
      tick;
      check("resume_oval_1", oval, 0);
      tick;
      check("resume_oval_2", oval, 1);
      check("resume_od0", od[7:0], 8'hBD);
      ival = 1'b0;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
